// File: rtl/encode_instr_serializer_pkg.sv
// Shared definitions for the instruction byte serializer: FSM state
// encodings, fixed byte constants, the field-length saturation limit and
// the latched descriptor layout.
package encode_instr_serializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PFX   = 3'd1,
    ST_ESC   = 3'd2,
    ST_OPC   = 3'd3,
    ST_MODRM = 3'd4,
    ST_SIB   = 3'd5,
    ST_DISP  = 3'd6,
    ST_IMM   = 3'd7
  } state_e;

  localparam logic [7:0] ESCAPE_BYTE        = 8'h0F;
  localparam logic [7:0] OPSIZE_PREFIX_BYTE = 8'h66;

  // Longest displacement / immediate field the serializer will emit.
  localparam int unsigned FIELD_LEN_MAX = 4;

  // Descriptor fields that are emitted as whole bytes; disp/imm live in
  // their own shifters.
  typedef struct packed {
    logic       pfx;
    logic       esc;
    logic [7:0] opc;
    logic       has_modrm;
    logic [7:0] modrm;
    logic       has_sib;
    logic [7:0] sib;
  } desc_t;

  // Clamp a requested field length to the supported maximum.
  function automatic logic [2:0] sat_field_len(input logic [2:0] len,
                                               input int unsigned max_len);
    if (32'(len) > max_len) return 3'(max_len);
    return len;
  endfunction

endpackage

// File: rtl/encode_field_shifter.sv
// Little-endian byte emitter for one multi-byte field (displacement or
// immediate): load the value and its byte count, then shift one byte out
// per accepted output byte.
module encode_field_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [2:0]  load_len,
  input  logic        shift,
  output logic [7:0]  cur_byte,
  output logic [7:0]  next_byte,
  output logic [2:0]  count
);

  logic [31:0] data_q, data_d;
  logic [2:0]  cnt_q, cnt_d;

  // Load has priority; a shift drops the emitted byte and counts down.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load) begin
      data_d = load_data;
      cnt_d  = load_len;
    end else if (shift && (cnt_q != 3'd0)) begin
      data_d = {8'h00, data_q[31:8]};
      cnt_d  = cnt_q - 3'd1;
    end
  end

  // Byte counter: reset so the field reads as empty out of reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) cnt_q <= 3'd0;
    else     cnt_q <= cnt_d;
  end

  // Field data register.
  always_ff @(posedge clk) begin
    // NOTE: pure datapath storage is left unreset; it is always loaded before it is read.
    data_q <= data_d;
  end

  assign cur_byte  = data_q[7:0];
  assign next_byte = data_q[15:8];
  assign count     = cnt_q;

endmodule

// File: rtl/encode_instr_serializer.sv
// Decoded x86 instruction descriptor -> machine bytes, one byte per cycle on
// a valid/ready stream. Order: [0x66] [0x0F] opcode [ModRM] [SIB] [disp] [imm].
// Optional feature macro: ENCODE_OPSIZE_PREFIX_EN enables the 0x66
// operand-size prefix requested through in_opsize16.
module encode_instr_serializer
  import encode_instr_serializer_pkg::*;
#(
  parameter int unsigned MAX_FIELD_BYTES = FIELD_LEN_MAX,
  parameter int unsigned LEN_W           = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_is_2byte,
  input  logic [7:0]       in_opc,
  input  logic             in_opc_has_reg,
  input  logic [2:0]       in_reg,
  input  logic             in_has_modrm,
  input  logic [7:0]       in_modrm,
  input  logic             in_has_sib,
  input  logic [7:0]       in_sib,
  input  logic [2:0]       in_disp_len,
  input  logic [31:0]      in_disp,
  input  logic [2:0]       in_imm_len,
  input  logic [31:0]      in_imm,
  input  logic             in_opsize16,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_last,
  output logic [LEN_W-1:0] instr_len,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [7:0]       out_byte_q, out_byte_d;
  logic [LEN_W-1:0] instr_len_q, instr_len_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  desc_t            desc_q, desc_d;

  logic             accept, hs;
  logic             pfx_in, sib_in;
  logic [7:0]       opc_in;
  logic [2:0]       disp_len_sat, imm_len_sat;
  logic [LEN_W-1:0] total_len;
  state_e           first_state, adv_state;
  logic [7:0]       first_byte, adv_byte;
  logic [7:0]       disp_cur, disp_next, imm_cur, imm_next;
  logic [2:0]       disp_cnt, imm_cnt;

  assign accept = in_valid && (state_q == ST_IDLE);
  assign hs     = out_valid_q && out_ready;

`ifdef ENCODE_OPSIZE_PREFIX_EN
  assign pfx_in = in_opsize16;
`else
  logic unused_opsize16;
  assign unused_opsize16 = in_opsize16;
  assign pfx_in          = 1'b0;
`endif

  assign opc_in       = in_opc_has_reg ? (in_opc | {5'b00000, in_reg}) : in_opc;
  assign sib_in       = in_has_sib && in_has_modrm;
  assign disp_len_sat = sat_field_len(in_disp_len, MAX_FIELD_BYTES);
  assign imm_len_sat  = sat_field_len(in_imm_len, MAX_FIELD_BYTES);
  assign total_len    = LEN_W'(pfx_in) + LEN_W'(in_is_2byte) + LEN_W'(1'b1)
                      + LEN_W'(in_has_modrm) + LEN_W'(sib_in)
                      + LEN_W'(disp_len_sat) + LEN_W'(imm_len_sat);

  encode_field_shifter u_disp (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data (in_disp),
    .load_len  (disp_len_sat),
    .shift     (hs && (state_q == ST_DISP)),
    .cur_byte  (disp_cur),
    .next_byte (disp_next),
    .count     (disp_cnt)
  );

  encode_field_shifter u_imm (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data (in_imm),
    .load_len  (imm_len_sat),
    .shift     (hs && (state_q == ST_IMM)),
    .cur_byte  (imm_cur),
    .next_byte (imm_next),
    .count     (imm_cnt)
  );

  // Latch the byte-sized descriptor fields on accept.
  always_comb begin
    desc_d = desc_q;
    if (accept) begin
      desc_d.pfx       = pfx_in;
      desc_d.esc       = in_is_2byte;
      desc_d.opc       = opc_in;
      desc_d.has_modrm = in_has_modrm;
      desc_d.modrm     = in_modrm;
      desc_d.has_sib   = sib_in;
      desc_d.sib       = in_sib;
    end
  end

  // Descriptor register.
  always_ff @(posedge clk) begin
    desc_q <= desc_d;
  end

  // Pick the first byte at accept and the next present field after each
  // non-final handshake, skipping absent fields with no bubble.
  always_comb begin
    state_e after_sib;
    state_e after_modrm;
    state_e after_opc;

    first_state = pfx_in ? ST_PFX : (in_is_2byte ? ST_ESC : ST_OPC);
    first_byte  = pfx_in ? OPSIZE_PREFIX_BYTE : (in_is_2byte ? ESCAPE_BYTE : opc_in);

    after_sib   = (disp_cnt != 3'd0) ? ST_DISP : ST_IMM;
    after_modrm = desc_q.has_sib ? ST_SIB : after_sib;
    after_opc   = desc_q.has_modrm ? ST_MODRM : after_sib;

    unique case (state_q)
      ST_PFX:   adv_state = desc_q.esc ? ST_ESC : ST_OPC;
      ST_ESC:   adv_state = ST_OPC;
      ST_OPC:   adv_state = after_opc;
      ST_MODRM: adv_state = after_modrm;
      ST_SIB:   adv_state = after_sib;
      ST_DISP:  adv_state = (disp_cnt > 3'd1) ? ST_DISP : ST_IMM;
      ST_IMM:   adv_state = ST_IMM;
      default:  adv_state = ST_IDLE;
    endcase

    unique case (adv_state)
      ST_PFX:   adv_byte = OPSIZE_PREFIX_BYTE;
      ST_ESC:   adv_byte = ESCAPE_BYTE;
      ST_OPC:   adv_byte = desc_q.opc;
      ST_MODRM: adv_byte = desc_q.modrm;
      ST_SIB:   adv_byte = desc_q.sib;
      ST_DISP:  adv_byte = (state_q == ST_DISP) ? disp_next : disp_cur;
      ST_IMM:   adv_byte = (state_q == ST_IMM) ? imm_next : imm_cur;
      default:  adv_byte = 8'h00;
    endcase
  end

  // FSM next values: outputs are computed one cycle ahead and registered.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_byte_d  = out_byte_q;
    instr_len_d = instr_len_q;
    rem_d       = rem_q;

    if (state_q == ST_IDLE) begin
      if (accept) begin
        state_d     = first_state;
        out_valid_d = 1'b1;
        out_byte_d  = first_byte;
        out_last_d  = (total_len == LEN_W'(1));
        instr_len_d = total_len;
        rem_d       = total_len;
      end
    end else if (hs) begin
      if (out_last_q) begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_byte_d  = 8'h00;
        rem_d       = '0;
      end else begin
        state_d    = adv_state;
        out_byte_d = adv_byte;
        rem_d      = rem_q - LEN_W'(1);
        out_last_d = (rem_q == LEN_W'(2));
      end
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_byte_q  <= 8'h00;
      instr_len_q <= '0;
      rem_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_byte_q  <= out_byte_d;
      instr_len_q <= instr_len_d;
      rem_q       <= rem_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_byte  = out_byte_q;
  assign instr_len = instr_len_q;

endmodule

// File: tb/tb_encode_instr_serializer.sv
// Self-checking bench for encode_instr_serializer: a byte-queue model of the
// encoding rules, a per-cycle compare process, directed literal streams and
// randomized descriptors with random backpressure.
module tb_encode_instr_serializer;

  typedef logic [7:0] bq_t[$];

  typedef struct packed {
    logic        is_2byte;
    logic [7:0]  opc;
    logic        has_reg;
    logic [2:0]  rg;
    logic        has_modrm;
    logic [7:0]  modrm;
    logic        has_sib;
    logic [7:0]  sib;
    logic [2:0]  disp_len;
    logic [31:0] disp;
    logic [2:0]  imm_len;
    logic [31:0] imm;
    logic        opsize16;
  } tdesc_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  tdesc_t     cur_desc = '0;
  logic       in_ready, out_valid, out_last, busy;
  logic [7:0] out_byte;
  logic [3:0] instr_len;

  int tests = 0;
  int fails = 0;

  bq_t  exp_q;
  bq_t  got_q;
  int   exp_len = 0;
  int   last_len = -1;
  int   ready_mode = 0;
  bq_t  ready_script;

  always #5 clk = ~clk;

  encode_instr_serializer dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_is_2byte    (cur_desc.is_2byte),
    .in_opc         (cur_desc.opc),
    .in_opc_has_reg (cur_desc.has_reg),
    .in_reg         (cur_desc.rg),
    .in_has_modrm   (cur_desc.has_modrm),
    .in_modrm       (cur_desc.modrm),
    .in_has_sib     (cur_desc.has_sib),
    .in_sib         (cur_desc.sib),
    .in_disp_len    (cur_desc.disp_len),
    .in_disp        (cur_desc.disp),
    .in_imm_len     (cur_desc.imm_len),
    .in_imm         (cur_desc.imm),
    .in_opsize16    (cur_desc.opsize16),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_byte       (out_byte),
    .out_last       (out_last),
    .instr_len      (instr_len),
    .busy           (busy)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference encoding: the byte list an instruction descriptor must produce.
  function automatic void model_bytes(input tdesc_t d, output bq_t q);
    int dl;
    int il;
    q = {};
`ifdef ENCODE_OPSIZE_PREFIX_EN
    if (d.opsize16) q.push_back(8'h66);
`endif
    if (d.is_2byte) q.push_back(8'h0F);
    q.push_back(d.has_reg ? (d.opc | {5'b00000, d.rg}) : d.opc);
    if (d.has_modrm) q.push_back(d.modrm);
    if (d.has_modrm && d.has_sib) q.push_back(d.sib);
    dl = (int'(d.disp_len) > 4) ? 4 : int'(d.disp_len);
    il = (int'(d.imm_len) > 4) ? 4 : int'(d.imm_len);
    for (int i = 0; i < dl; i++) q.push_back(d.disp[8*i +: 8]);
    for (int i = 0; i < il; i++) q.push_back(d.imm[8*i +: 8]);
  endfunction

  function automatic tdesc_t rand_desc();
    tdesc_t d;
    d.is_2byte  = 1'($urandom_range(0, 1));
    d.opc       = 8'($urandom);
    d.has_reg   = 1'($urandom_range(0, 1));
    d.rg        = 3'($urandom);
    if (d.has_reg) d.opc[2:0] = 3'b000;
    d.has_modrm = 1'($urandom_range(0, 1));
    d.modrm     = 8'($urandom);
    d.has_sib   = 1'($urandom_range(0, 1));
    d.sib       = 8'($urandom);
    d.disp_len  = 3'($urandom);
    d.disp      = $urandom;
    d.imm_len   = 3'($urandom);
    d.imm       = $urandom;
    d.opsize16  = 1'($urandom_range(0, 1));
    return d;
  endfunction

  // Consumer ready: constant, random, or a scripted per-byte sequence.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: out_ready = ($urandom_range(0, 3) != 0);
      2: if (out_valid && ready_script.size() != 0) out_ready = ready_script.pop_front();
         else out_ready = 1'b1;
      default: out_ready = 1'b1;
    endcase
  end

  // Per-cycle compare against the model, sampled mid-cycle.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  logic       prev_last = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
      check("busy", 32'(busy), 32'(exp_q.size() != 0));
      if (out_valid && exp_q.size() != 0) begin
        check("out_byte", 32'(out_byte), 32'(exp_q[0]));
        check("out_last", 32'(out_last), 32'(exp_q.size() == 1));
        if (prev_stall) begin
          check("stall_byte_hold", 32'(out_byte), 32'(prev_byte));
          check("stall_last_hold", 32'(out_last), 32'(prev_last));
        end
        if (out_last) begin
          check("instr_len", 32'(instr_len), 32'(exp_len));
          last_len = int'(instr_len);
        end
        if (out_ready) begin
          got_q.push_back(out_byte);
          void'(exp_q.pop_front());
        end
        prev_stall = !out_ready;
        prev_byte  = out_byte;
        prev_last  = out_last;
      end else begin
        prev_stall = 1'b0;
      end
      if (in_valid && in_ready) begin
        bq_t q;
        model_bytes(cur_desc, q);
        exp_q   = q;
        exp_len = q.size();
      end
    end
  end

  // All drivers below run at posedge+1.
  task automatic send(input tdesc_t d);
    int n;
    n = 0;
    cur_desc = d;
    in_valid = 1'b1;
    while (!in_ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 1000) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    cur_desc = rand_desc();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((out_valid || exp_q.size() != 0) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) check("idle_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_stream(input string name, input bq_t e);
    check({name, "_count"}, 32'(got_q.size()), 32'(e.size()));
    if (got_q.size() == e.size())
      for (int i = 0; i < e.size(); i++) check({name, "_byte"}, 32'(got_q[i]), 32'(e[i]));
  endtask

  task automatic directed(input string name, input tdesc_t d, input bq_t e);
    got_q.delete();
    send(d);
    wait_idle();
    check_stream(name, e);
    check({name, "_len"}, 32'(last_len), 32'(e.size()));
  endtask

  initial begin
    tdesc_t d;
    bq_t    e;
    bq_t    m;
    int     n;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_byte", 32'(out_byte), 32'd0);
    check("rst_instr_len", 32'(instr_len), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Pin the model with a hand-encoded instruction.
    d = '0; d.opc = 8'hB8; d.has_reg = 1'b1; d.rg = 3'd3; d.imm_len = 3'd4; d.imm = 32'h12345678;
    model_bytes(d, m);
    e = '{8'hBB, 8'h78, 8'h56, 8'h34, 8'h12};
    check("model_pin_count", 32'(m.size()), 32'(e.size()));
    if (m.size() == e.size())
      for (int i = 0; i < e.size(); i++) check("model_pin_byte", 32'(m[i]), 32'(e[i]));

    d = '0; d.opc = 8'h90;
    directed("nop", d, '{8'h90});

    d = '0; d.opc = 8'h01; d.has_modrm = 1'b1; d.modrm = 8'hC8;
    directed("add", d, '{8'h01, 8'hC8});

    d = '0; d.is_2byte = 1'b1; d.opc = 8'hAF; d.has_modrm = 1'b1; d.modrm = 8'h44;
    d.has_sib = 1'b1; d.sib = 8'h24; d.disp_len = 3'd1; d.disp = 32'h00000008;
    directed("imul", d, '{8'h0F, 8'hAF, 8'h44, 8'h24, 8'h08});

    d = '0; d.opc = 8'hB8; d.has_reg = 1'b1; d.rg = 3'd3; d.imm_len = 3'd4; d.imm = 32'h12345678;
    directed("mov_imm32", d, '{8'hBB, 8'h78, 8'h56, 8'h34, 8'h12});

`ifdef ENCODE_OPSIZE_PREFIX_EN
    d.opsize16 = 1'b1; d.imm_len = 3'd2;
    directed("mov_imm16", d, '{8'h66, 8'hBB, 8'h78, 8'h56});
`endif

    d = '0; d.opc = 8'h90; d.has_sib = 1'b1; d.sib = 8'h24;
    directed("sib_no_modrm", d, '{8'h90});

    d = '0; d.opc = 8'h8B; d.has_modrm = 1'b1; d.modrm = 8'h80; d.disp_len = 3'd7; d.disp = 32'h11223344;
    directed("disp_sat", d, '{8'h8B, 8'h80, 8'h44, 8'h33, 8'h22, 8'h11});

    d = '0; d.opc = 8'h8B; d.has_modrm = 1'b1; d.modrm = 8'h80; d.disp_len = 3'd3; d.disp = 32'h00ABCDEF;
    directed("disp3", d, '{8'h8B, 8'h80, 8'hEF, 8'hCD, 8'hAB});

    // Backpressure 1,0,0,1 across the displacement bytes.
    ready_script = '{8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd1};
    ready_mode = 2;
    d = '0; d.opc = 8'h8B; d.has_modrm = 1'b1; d.modrm = 8'h45; d.disp_len = 3'd4; d.disp = 32'hDDCCBBAA;
    directed("backpressure", d, '{8'h8B, 8'h45, 8'hAA, 8'hBB, 8'hCC, 8'hDD});
    ready_mode = 0;

    // Reset after the second byte of a 5-byte instruction.
    got_q.delete();
    d = '0; d.is_2byte = 1'b1; d.opc = 8'hAF; d.has_modrm = 1'b1; d.modrm = 8'h44;
    d.has_sib = 1'b1; d.sib = 8'h24; d.disp_len = 3'd1; d.disp = 32'h00000008;
    send(d);
    n = 0;
    while (got_q.size() < 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_rst_progress", 32'(got_q.size()), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_last", 32'(out_last), 32'd0);
    check("mid_rst_out_byte", 32'(out_byte), 32'd0);
    check("mid_rst_instr_len", 32'(instr_len), 32'd0);
    d = '0; d.opc = 8'h90;
    directed("nop_after_rst", d, '{8'h90});

    // Randomized descriptors, back-to-back or with gaps, random backpressure.
    for (int k = 0; k < 400; k++) begin
      ready_mode = int'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      send(rand_desc());
    end
    wait_idle();
    ready_mode = 0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
